// File: rtl/seq_bin_bcd.sv
// Sequential fixed-point binary to BCD converter: double-dabble for the integer part,
// multiply-by-ten for the fraction. Define SEQ_BIN_BCD_SIGNED_EN for two's complement input.
module seq_bin_bcd #(
  parameter int IN_W   = 10,
  parameter int FRAC_W = 2,
  parameter int DIGITS = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [IN_W-1:0]                         bin,
  output logic                                    busy,
  output logic                                    done,
  output logic [4*DIGITS-1:0]                     bcd_int,
  output logic [4*((FRAC_W > 0) ? FRAC_W : 1)-1:0] bcd_frac,
  output logic                                    ovf,
  output logic                                    sign
);

  localparam int IW  = IN_W - FRAC_W;
  localparam int FW1 = (FRAC_W > 0) ? FRAC_W : 1;
  localparam int CW  = $clog2(IN_W + 1);

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  // Accumulator digit count covers the full IW-bit range, not just DIGITS
  localparam int AD = dec_digits(IW);
  localparam int EW = (AD > DIGITS) ? AD : DIGITS;

  typedef enum logic [1:0] {IDLE, INT, FRAC, DONE} state_t;

  state_t              state_r;
  logic [IW-1:0]       int_sh_r;
  logic [4*AD-1:0]     acc_r;
  logic [FW1-1:0]      res_r;
  logic [4*FW1-1:0]    frac_acc_r;
  logic [CW-1:0]       cnt_r;
  logic                sign_pend_r;

  logic [IN_W-1:0]     mag_s;
  logic                sign_cap_s;
  logic [4*AD-1:0]     adj_s;
  logic [4*AD-1:0]     acc_nx_s;
  logic [FW1+3:0]      t_s;
  logic [3:0]          digit_s;
  logic [4*FW1-1:0]    frac_nx_s;
  logic [4*EW-1:0]     acc_ext_s;
  logic                ovf_s;
  logic [4*DIGITS-1:0] bcd_sat_s;

`ifdef SEQ_BIN_BCD_SIGNED_EN
  // Magnitude as IN_W bits so the most-negative input still fits
  always_comb begin
    if (bin[IN_W-1]) begin
      mag_s      = ~bin + IN_W'(1);
      sign_cap_s = 1'b1;
    end else begin
      mag_s      = bin;
      sign_cap_s = 1'b0;
    end
  end
`else
  assign mag_s      = bin;
  assign sign_cap_s = 1'b0;
`endif

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next integer bit
  always_comb begin
    adj_s = acc_r;
    for (int i = 0; i < AD; i++) begin
      if (acc_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = acc_r[4*i +: 4];
      end
    end
    if (state_r == INT) begin
      acc_nx_s = (adj_s << 1) | (4*AD)'(int_sh_r[IW-1]);
    end else begin
      acc_nx_s = acc_r;
    end
  end

  // Fraction step: residue times ten, integer part of the product is the next digit
  always_comb begin
    t_s     = ({4'd0, res_r} << 3) + ({4'd0, res_r} << 1);
    digit_s = t_s[FRAC_W +: 4];
    if (state_r == FRAC) begin
      frac_nx_s = (frac_acc_r << 4) | (4*FW1)'(digit_s);
    end else begin
      frac_nx_s = frac_acc_r;
    end
  end

  // Overflow detection and saturation of the integer digits
  always_comb begin
    acc_ext_s = (4*EW)'(acc_nx_s);
    ovf_s     = 1'b0;
    for (int i = 0; i < EW; i++) begin
      ovf_s = ovf_s | ((i >= DIGITS) && (acc_ext_s[4*i +: 4] != 4'd0));
    end
    bcd_sat_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf_s) begin
        bcd_sat_s[4*i +: 4] = 4'd9;
      end else begin
        bcd_sat_s[4*i +: 4] = acc_ext_s[4*i +: 4];
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      int_sh_r    <= '0;
      acc_r       <= '0;
      res_r       <= '0;
      frac_acc_r  <= '0;
      cnt_r       <= '0;
      sign_pend_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd_int     <= '0;
      bcd_frac    <= '0;
      ovf         <= 1'b0;
      sign        <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            int_sh_r    <= mag_s[IN_W-1:FRAC_W];
            res_r       <= (FRAC_W > 0) ? mag_s[FW1-1:0] : '0;
            acc_r       <= '0;
            frac_acc_r  <= '0;
            cnt_r       <= '0;
            sign_pend_r <= sign_cap_s;
            busy        <= 1'b1;
            state_r     <= (IW > 0) ? INT : FRAC;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        INT: begin
          acc_r    <= acc_nx_s;
          int_sh_r <= int_sh_r << 1;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(IW - 1)) begin
            cnt_r <= '0;
            if (FRAC_W > 0) begin
              state_r <= FRAC;
            end else begin
              state_r  <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              bcd_int  <= bcd_sat_s;
              bcd_frac <= frac_nx_s;
              ovf      <= ovf_s;
              sign     <= sign_pend_r;
            end
          end
        end
        FRAC: begin
          res_r      <= t_s[FW1-1:0];
          frac_acc_r <= frac_nx_s;
          cnt_r      <= cnt_r + CW'(1);
          if (cnt_r == CW'(FRAC_W - 1)) begin
            cnt_r    <= '0;
            state_r  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd_int  <= bcd_sat_s;
            bcd_frac <= frac_nx_s;
            ovf      <= ovf_s;
            sign     <= sign_pend_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
